// File: rtl/si_frame_decoder.sv
// Serial register-frame decoder: one address byte then LSB-first data bytes,
// with an inter-byte timeout that abandons partial frames.
module si_frame_decoder #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_rdy,
  output logic [REG_ADDR_WIDTH-1:0] si_addr,
  output logic [REG_DATA_WIDTH-1:0] si_data,
  output logic                      si_rdy,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int NB = REG_DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] LAST = 2'(NB - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    EMIT
  } state_t;

  state_t                    state;
  logic [1:0]                byte_cnt;
  logic [TW-1:0]             tmo;
  logic [REG_ADDR_WIDTH-1:0] addr_sh;
  logic [REG_DATA_WIDTH-1:0] data_sh;
  logic [REG_DATA_WIDTH-1:0] data_next;

  // Shadow with the incoming byte merged in, so EMIT can present it at once.
  always_comb begin
    data_next = data_sh;
    for (int i = 0; i < NB; i++) begin
      if (byte_cnt == 2'(i)) data_next[i*8 +: 8] = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      tmo       <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      si_addr   <= '0;
      si_data   <= '0;
      si_rdy    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      si_rdy    <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE, EMIT: begin
          tmo <= '0;
          if (rx_rdy) begin
            addr_sh  <= rx_data;
            byte_cnt <= '0;
            state    <= DATA;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: begin
          if (rx_rdy) begin
            data_sh  <= data_next;
            tmo      <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == LAST) begin
              state   <= EMIT;
              busy    <= 1'b0;
              si_rdy  <= 1'b1;
              si_addr <= addr_sh;
              si_data <= data_next;
            end
          end else if (tmo == TMAX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            tmo       <= '0;
            byte_cnt  <= '0;
            addr_sh   <= '0;
            data_sh   <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_si_frame_decoder.sv
// Scoreboard bench for si_frame_decoder: expected frames are queued as bytes
// are driven and checked when si_rdy strobes.
module tb_si_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic [7:0]  si_addr;
  logic [15:0] si_data;
  logic        si_rdy;
  logic        frame_err;
  logic        busy;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_cnt = 0;
  int   err_cnt = 0;

  si_frame_decoder #(
    .REG_ADDR_WIDTH(8),
    .REG_DATA_WIDTH(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .si_addr  (si_addr),
    .si_data  (si_data),
    .si_rdy   (si_rdy),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Monitor: pop and compare on every strobe.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (si_rdy === 1'b1) begin
      rdy_cnt++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: addr=%h data=%h required none",
                 si_addr, si_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (si_addr !== e.a || si_data !== e.d) begin
          bad++;
          $display("FAIL strobe_value: addr=%h data=%h required %h/%h",
                   si_addr, si_data, e.a, e.d);
        end
      end
    end
  end

  // Caller is aligned #1 after a posedge; returns at the same alignment.
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_rdy  = 1'b0;
    rx_data = 8'hxx;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({si_rdy, frame_err, busy} !== 3'b000 || si_addr !== 8'h00 ||
        si_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: rdy/err/busy=%b addr=%h data=%h required 0",
               {si_rdy, frame_err, busy}, si_addr, si_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle;
    int viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({si_rdy, frame_err, busy} !== 3'b000 || si_addr !== 8'h00 ||
          si_data !== 16'h0000) viol++;
    end
    @(posedge clk);
    #1;
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL idle_quiet: %0d bad cycles required 0", viol);
    end
  endtask

  task automatic test_basic;
    int r0 = rdy_cnt;
    send(8'h03, 0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_hi: got %b required 1", busy);
    end
    #4;
    send(8'h01, 9);
    q.push_back('{a: 8'h03, d: 16'h0001});
    send(8'h00, 9);
    @(negedge clk);
    total++;
    if (si_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_emit: rdy=%b busy=%b required 1/0", si_rdy, busy);
    end
    #4;
    idle(3);
    chk("basic_strobes", 32'(rdy_cnt - r0), 32'd1);
    chk("basic_hold_addr", 32'(si_addr), 32'h03);
    chk("basic_hold_data", 32'(si_data), 32'h0001);
  endtask

  task automatic test_timeout;
    int r0 = rdy_cnt;
    int e0 = err_cnt;
    send(8'h03, 0);
    idle(20);
    chk("timeout_err_once", 32'(err_cnt - e0), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_no_rdy", 32'(rdy_cnt - r0), 32'd0);
    send(8'h05, 0);
    q.push_back('{a: 8'h05, d: 16'h1234});
    send(8'h34, 2);
    send(8'h12, 2);
    idle(3);
    chk("timeout_recover", 32'(rdy_cnt - r0), 32'd1);
  endtask

  task automatic test_back_to_back;
    int r0 = rdy_cnt;
    q.push_back('{a: 8'h01, d: 16'h55AA});
    q.push_back('{a: 8'h02, d: 16'h2211});
    send(8'h01, 0);
    send(8'hAA, 0);
    send(8'h55, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    idle(3);
    chk("b2b_strobes", 32'(rdy_cnt - r0), 32'd2);
    chk("b2b_last_data", 32'(si_data), 32'h2211);
  endtask

  task automatic test_boundary;
    int e0 = err_cnt;
    send(8'h07, 0);
    send(8'h10, 15);
    chk("boundary_busy", 32'(busy), 32'd1);
    q.push_back('{a: 8'h07, d: 16'h0010});
    send(8'h00, 3);
    idle(3);
    chk("boundary_no_err", 32'(err_cnt - e0), 32'd0);
    chk("boundary_data", 32'(si_data), 32'h0010);
  endtask

  task automatic test_reset_mid;
    int r0 = rdy_cnt;
    int e0 = err_cnt;
    send(8'h03, 0);
    send(8'h44, 1);
    rst = 1'b1;
    rx_rdy = 1'b1;
    rx_data = 8'h5A;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_rdy = 1'b0;
    chk("rstmid_addr", 32'(si_addr), 32'h00);
    chk("rstmid_data", 32'(si_data), 32'h0000);
    chk("rstmid_busy", 32'(busy), 32'd0);
    idle(25);
    chk("rstmid_no_err", 32'(err_cnt - e0), 32'd0);
    chk("rstmid_no_rdy", 32'(rdy_cnt - r0), 32'd0);
    send(8'h09, 0);
    q.push_back('{a: 8'h09, d: 16'h0002});
    send(8'h02, 1);
    send(8'h00, 1);
    idle(3);
    chk("rstmid_addr2", 32'(si_addr), 32'h09);
    chk("rstmid_data2", 32'(si_data), 32'h0002);
  endtask

  initial begin
    test_reset;
    test_idle;
    test_basic;
    test_timeout;
    test_back_to_back;
    test_boundary;
    test_reset_mid;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/si_frame_decoder.md
SI_FRAME_DECODER -- requirements
Module: si_frame_decoder

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 8, width of si_addr; SHALL be 8.
REQ-002 Parameter REG_DATA_WIDTH, default 16, width of si_data; SHALL be a multiple of 8, with 8 <= value <= 32.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles; SHALL be >= 2.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_data  input  8  received byte from UART receiver.
REQ-007 rx_rdy  input  1  one-cycle strobe; rx_data valid when high.
REQ-008 si_addr  output  REG_ADDR_WIDTH  register address of last completed frame.
REQ-009 si_data  output  REG_DATA_WIDTH  register data of last completed frame.
REQ-010 si_rdy  output  1  one-cycle strobe; si_addr/si_data valid when high.
REQ-011 frame_err  output  1  one-cycle strobe on inter-byte timeout.
REQ-012 busy  output  1  high while a frame is partially received.

Function
REQ-013 Frame format: 1 address byte, then NB = REG_DATA_WIDTH/8 data bytes, least-significant byte first.
REQ-014 FSM states: IDLE (await address byte), DATA (collecting data bytes), EMIT (strobe cycle).
REQ-015 IDLE + rx_rdy: capture rx_data into address shadow; clear byte counter; go to DATA.
REQ-016 DATA + rx_rdy: write rx_data into data shadow byte[byte counter]; increment counter; after byte NB-1, go to EMIT.
REQ-017 EMIT: si_addr/si_data load from shadows, si_rdy = 1 for exactly this cycle; next state IDLE.
REQ-018 Latency: si_rdy asserts the cycle after the rx_rdy of the last data byte.
REQ-019 rx_rdy during EMIT SHALL be accepted as the address byte of a new frame (next state DATA); no byte is lost.
REQ-020 si_addr/si_data SHALL hold their values between strobes and update only in EMIT.
REQ-021 Timeout counter: cleared on every accepted byte and in IDLE; increments each cycle in DATA without rx_rdy.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 in DATA without rx_rdy: go to IDLE, pulse frame_err for 1 cycle, discard shadows, and leave si_rdy low.
REQ-023 rx_rdy in the same cycle the timeout would fire: the byte wins; no frame_err; counter clears.
REQ-024 busy = 1 in DATA; 0 in IDLE and EMIT.
REQ-025 Counter width SHALL be clog2(TIMEOUT_CYCLES); no wrap-around is reachable.
REQ-026 rx_data SHALL be ignored when rx_rdy = 0.

Reset
REQ-027 With rst = 1 at a clk edge: state IDLE; si_addr = 0, si_data = 0, si_rdy = 0, frame_err = 0, busy = 0; byte counter, timeout counter and shadows = 0.
REQ-028 rst SHALL override all other inputs, including rx_rdy in the same cycle.
REQ-029 Reset mid-frame SHALL discard the partial frame with no si_rdy and no frame_err.

Verification
REQ-030 Setup: TIMEOUT_CYCLES = 16, REG_DATA_WIDTH = 16. Bytes 0x03, 0x01, 0x00, spaced 10 cycles -> 1 cycle after third strobe: si_rdy = 1 for 1 cycle, si_addr = 0x03, si_data = 0x0001; busy high from after first byte until EMIT.
REQ-031 Byte 0x03, then 16 idle cycles -> frame_err pulses once, busy drops, no si_rdy; then 0x05, 0x34, 0x12 -> si_addr = 0x05, si_data = 0x1234.
REQ-032 Back-to-back frames (0x01, 0xAA, 0x55) and (0x02, 0x11, 0x22), with the second address byte arriving in the EMIT cycle -> two si_rdy strobes: 0x01/0x55AA, then 0x02/0x2211.
REQ-033 Byte 0x07, then rx_rdy with 0x10 exactly 15 cycles later (timeout boundary) -> no frame_err; frame continues; 0x00 -> si_data = 0x0010.
REQ-034 Bytes 0x03, 0x44, then rst for 1 cycle, then 0x09, 0x02, 0x00 -> outputs zero after reset, no strobes; then si_addr = 0x09, si_data = 0x0002.
REQ-035 Idle bus for 1000 cycles after reset -> si_rdy, frame_err, busy stay 0; si_addr/si_data stay 0.
